// File: rtl/cam_pkg.sv
// Shared types and default geometry for the CAM sub-array: opcodes, FSM encoding and sizes.
package cam_pkg;

  localparam int unsigned DefCols     = 32;
  localparam int unsigned DefDataRows = 32;
  localparam int unsigned DefMetaRows = 8;

  typedef enum logic [2:0] {
    OpWrite     = 3'b000,
    OpUpdate    = 3'b001,
    OpSearch    = 3'b010,
    OpTagUpdate = 3'b011,
    OpAccClr    = 3'b100
  } cam_op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StChain = 2'b01,
    StHold  = 2'b10
  } cam_state_e;

endpackage

// File: rtl/cam_row_array.sv
// Row storage: one synchronous write port, one combinational read port, async clear.
module cam_row_array #(
  parameter int unsigned Cols = 32,
  parameter int unsigned Rows = 40,
  parameter int unsigned Aw   = 6
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            we_i,
  input  logic [Aw-1:0]   waddr_i,
  input  logic [Cols-1:0] wdata_i,
  input  logic [Aw-1:0]   raddr_i,
  output logic [Cols-1:0] rdata_o
);

  logic [Cols-1:0] mem_q [Rows];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Rows); i++) mem_q[i] <= '0;
    end else if (we_i && (int'(waddr_i) < int'(Rows))) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Addresses beyond the populated rows read as zero.
  always_comb begin
    rdata_o = '0;
    if (int'(raddr_i) < int'(Rows)) rdata_o = mem_q[raddr_i];
  end

endmodule

// File: rtl/cam_subarray_seq.sv
// Sequenced CAM sub-array: AND-chained bit searches over stored rows with a tag/OR accumulator.
module cam_subarray_seq
  import cam_pkg::*;
#(
  parameter int unsigned COLS      = DefCols,
  parameter int unsigned DATA_ROWS = DefDataRows,
  parameter int unsigned META_ROWS = DefMetaRows,
  localparam int unsigned ROW_AW   = $clog2(DATA_ROWS + META_ROWS)
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              chip_enable,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ROW_AW-1:0] cmd_row,
  input  logic [COLS-1:0]   cmd_data,
  input  logic [COLS-1:0]   cmd_mask,
  input  logic              cmd_bit,
  input  logic              cmd_last,
  input  logic              acc_en,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [COLS-1:0]   rsp_tag,
  output logic [COLS-1:0]   rsp_acc,
  output logic              err
);

  localparam int unsigned NumRows = DATA_ROWS + META_ROWS;

  cam_state_e state_q, state_d;
  logic [COLS-1:0] chain_q, chain_d;
  logic [COLS-1:0] last_tag_q, last_tag_d;
  logic [COLS-1:0] acc_q, acc_d;
  logic            err_q, err_d;
  logic            rdy_en_q, rdy_en_d;

  logic            accept;
  logic            row_ok;
  cam_op_e         op;
  logic [COLS-1:0] rd_data;
  logic [COLS-1:0] term;
  logic [COLS-1:0] result;
  logic            mem_we;
  logic [COLS-1:0] mem_wdata;

  assign op     = cam_op_e'(cmd_op);
  assign accept = cmd_valid & cmd_ready;
  assign row_ok = int'(cmd_row) < int'(NumRows);
  assign term   = row_ok ? ~(rd_data ^ {COLS{cmd_bit}}) : '0;
  assign result = (state_q == StIdle) ? term : (chain_q & term);

  cam_row_array #(
    .Cols (COLS),
    .Rows (NumRows),
    .Aw   (ROW_AW)
  ) u_rows (
    .clk_i   (CLK),
    .rst_ni  (RSTN),
    .we_i    (mem_we),
    .waddr_i (cmd_row),
    .wdata_i (mem_wdata),
    .raddr_i (cmd_row),
    .rdata_o (rd_data)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept && op == OpSearch) begin
      state_d = cmd_last ? StHold : StChain;
    end
    if (state_q == StHold && chip_enable && rsp_ready) state_d = StIdle;
  end

  // cmd_ready stays low out of reset until the first enabled edge.
  always_comb begin
    cmd_ready = chip_enable && rdy_en_q && (state_q != StHold);
    rsp_valid = (state_q == StHold);
    rsp_tag   = last_tag_q;
    rsp_acc   = acc_q;
    err       = err_q;
  end

  always_comb begin
    chain_d    = chain_q;
    last_tag_d = last_tag_q;
    acc_d      = acc_q;
    err_d      = err_q;
    rdy_en_d   = rdy_en_q | chip_enable;
    mem_we     = 1'b0;
    mem_wdata  = cmd_data;
    if (accept) begin
      case (op)
        OpWrite: begin
          mem_we = row_ok;
          err_d  = err_q | ~row_ok;
        end
        OpUpdate: begin
          mem_we    = row_ok;
          mem_wdata = (rd_data & ~cmd_mask) | ({COLS{cmd_bit}} & cmd_mask);
          err_d     = err_q | ~row_ok;
        end
        OpTagUpdate: begin
          mem_we    = row_ok;
          mem_wdata = (rd_data & ~last_tag_q) | ({COLS{cmd_bit}} & last_tag_q);
          err_d     = err_q | ~row_ok;
        end
        OpSearch: begin
          err_d   = err_q | ~row_ok;
          chain_d = result;
          if (cmd_last) begin
            last_tag_d = result;
            if (acc_en) acc_d = acc_q | result;
          end
        end
        OpAccClr: acc_d = '0;
        default:  err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      chain_q    <= '0;
      last_tag_q <= '0;
      acc_q      <= '0;
      err_q      <= 1'b0;
      rdy_en_q   <= 1'b0;
    end else begin
      chain_q    <= chain_d;
      last_tag_q <= last_tag_d;
      acc_q      <= acc_d;
      err_q      <= err_d;
      rdy_en_q   <= rdy_en_d;
    end
  end

endmodule

// File: tb/tb_cam_subarray_seq.sv
// Directed bench for cam_subarray_seq with hand-computed expectations.
module tb_cam_subarray_seq;

  localparam int unsigned Cols = 32;
  localparam int unsigned Aw   = 6;

  logic            CLK;
  logic            RSTN;
  logic            chip_enable;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [2:0]      cmd_op;
  logic [Aw-1:0]   cmd_row;
  logic [Cols-1:0] cmd_data;
  logic [Cols-1:0] cmd_mask;
  logic            cmd_bit;
  logic            cmd_last;
  logic            acc_en;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [Cols-1:0] rsp_tag;
  logic [Cols-1:0] rsp_acc;
  logic            err;

  int total;
  int bad;

  cam_subarray_seq dut (
    .CLK         (CLK),
    .RSTN        (RSTN),
    .chip_enable (chip_enable),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_row     (cmd_row),
    .cmd_data    (cmd_data),
    .cmd_mask    (cmd_mask),
    .cmd_bit     (cmd_bit),
    .cmd_last    (cmd_last),
    .acc_en      (acc_en),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_tag     (rsp_tag),
    .rsp_acc     (rsp_acc),
    .err         (err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Offer one command and return #1 after the edge that accepted it.
  task automatic send(input logic [2:0] op, input logic [Aw-1:0] row, input logic [31:0] data,
                      input logic [31:0] mask, input logic b, input logic last, input logic acc);
    int n;
    cmd_op    = op;
    cmd_row   = row;
    cmd_data  = data;
    cmd_mask  = mask;
    cmd_bit   = b;
    cmd_last  = last;
    acc_en    = acc;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (!cmd_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: cmd_ready got 0 expected 1");
    end
    @(posedge CLK);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic search(input logic [Aw-1:0] row, input logic b, input logic last,
                        input logic acc);
    send(3'b010, row, 32'h0, 32'h0, b, last, acc);
  endtask

  task automatic write(input logic [Aw-1:0] row, input logic [31:0] data);
    send(3'b000, row, data, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Check the held response, then complete the handshake.
  task automatic take(input string tag, input logic [31:0] exp_tag, input logic [31:0] exp_acc);
    check_eq({tag, "_valid"}, {31'b0, rsp_valid}, 32'h1);
    check_eq({tag, "_tag"}, rsp_tag, exp_tag);
    check_eq({tag, "_acc"}, rsp_acc, exp_acc);
    rsp_ready = 1'b1;
    @(posedge CLK);
    #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    RSTN = 1'b0;
    chip_enable = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 3'b0;
    cmd_row = '0;
    cmd_data = '0;
    cmd_mask = '0;
    cmd_bit = 1'b0;
    cmd_last = 1'b0;
    acc_en = 1'b0;
    rsp_ready = 1'b0;

    #12;
    check_eq("rst_ready", {31'b0, cmd_ready}, 32'h0);
    check_eq("rst_valid", {31'b0, rsp_valid}, 32'h0);
    check_eq("rst_tag", rsp_tag, 32'h0);
    check_eq("rst_acc", rsp_acc, 32'h0);
    check_eq("rst_err", {31'b0, err}, 32'h0);
    @(negedge CLK);
    RSTN = 1'b1;
    #1;
    check_eq("rel_ready_pre", {31'b0, cmd_ready}, 32'h0);
    @(posedge CLK);
    #1;
    check_eq("rel_ready_post", {31'b0, cmd_ready}, 32'h1);

    // Single-term chain over a written row.
    write(6'd3, 32'hF0F0F0F0);
    search(6'd3, 1'b1, 1'b1, 1'b0);
    check_eq("hold_ready", {31'b0, cmd_ready}, 32'h0);
    // Disabled block must hold HOLD even with rsp_ready high.
    chip_enable = 1'b0;
    rsp_ready   = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    rsp_ready = 1'b0;
    check_eq("ce0_valid", {31'b0, rsp_valid}, 32'h1);
    check_eq("ce0_ready", {31'b0, cmd_ready}, 32'h0);
    chip_enable = 1'b1;
    take("r050", 32'hF0F0F0F0, 32'h0);
    check_eq("r050_idle_ready", {31'b0, cmd_ready}, 32'h1);

    // Two-term chain across data and metadata rows, with backpressure.
    write(6'd0, 32'hFFFF0000);
    write(6'd33, 32'hFF00FF00);
    search(6'd0, 1'b1, 1'b0, 1'b0);
    search(6'd33, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK);
      #1;
      check_eq("r051_stable_tag", rsp_tag, 32'hFF000000);
      check_eq("r051_stable_ready", {31'b0, cmd_ready}, 32'h0);
    end
    take("r051", 32'hFF000000, 32'h0);

    // Accumulation and clear.
    write(6'd1, 32'h0000000F);
    write(6'd2, 32'h000000F0);
    search(6'd1, 1'b1, 1'b1, 1'b1);
    take("r052a", 32'h0000000F, 32'h0000000F);
    search(6'd2, 1'b1, 1'b1, 1'b1);
    take("r052b", 32'h000000F0, 32'h000000FF);
    send(3'b100, 6'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    search(6'd2, 1'b1, 1'b1, 1'b0);
    take("r052c", 32'h000000F0, 32'h0);

    // Tag-driven update of a zeroed row.
    write(6'd4, 32'h0000FFFF);
    search(6'd4, 1'b1, 1'b1, 1'b0);
    take("r053a", 32'h0000FFFF, 32'h0);
    send(3'b011, 6'd5, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    search(6'd5, 1'b1, 1'b1, 1'b0);
    take("r053b", 32'h0000FFFF, 32'h0);

    // Masked update, then a write inside an open chain seen by the later term.
    send(3'b001, 6'd7, 32'h0, 32'h00FF00FF, 1'b1, 1'b0, 1'b0);
    search(6'd4, 1'b1, 1'b0, 1'b0);
    write(6'd6, 32'h00FF00FF);
    search(6'd6, 1'b1, 1'b0, 1'b0);
    search(6'd7, 1'b0, 1'b1, 1'b0);
    take("mid_chain", 32'h0000FF00 & 32'h00FF00FF, 32'h0);

    // Out-of-range search and illegal opcode.
    check_eq("err_pre", {31'b0, err}, 32'h0);
    search(6'd40, 1'b0, 1'b1, 1'b0);
    check_eq("r054_err", {31'b0, err}, 32'h1);
    take("r054a", 32'h0, 32'h0);
    send(3'b111, 6'd3, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    check_eq("r054_err_sticky", {31'b0, err}, 32'h1);
    search(6'd3, 1'b1, 1'b1, 1'b0);
    take("r054b", 32'hF0F0F0F0, 32'h0);

    // Asynchronous reset mid-chain.
    search(6'd0, 1'b1, 1'b0, 1'b0);
    RSTN = 1'b0;
    #1;
    check_eq("r055_ready", {31'b0, cmd_ready}, 32'h0);
    check_eq("r055_valid", {31'b0, rsp_valid}, 32'h0);
    check_eq("r055_tag", rsp_tag, 32'h0);
    check_eq("r055_acc", rsp_acc, 32'h0);
    check_eq("r055_err", {31'b0, err}, 32'h0);
    #2;
    RSTN = 1'b1;
    search(6'd0, 1'b0, 1'b1, 1'b0);
    take("r055", 32'hFFFFFFFF, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
